// File: rtl/collision_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : collision_game_ctrl_pkg
// Purpose : Shared types and constants for the collision / game-state block.
//           Holds the game state encoding, the BCD score geometry and a
//           saturating BCD increment helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package collision_game_ctrl_pkg;

  // Game state encoding, also driven directly onto the game_state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam int              BCD_DIGIT_W  = 4;
  localparam int              SCORE_DIGITS = 3;
  localparam int              SCORE_W      = BCD_DIGIT_W * SCORE_DIGITS;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 12'h999;

  // Adds one to a 3-digit BCD value, rippling the carry ones->tens->hundreds.
  // The maximum value is returned unchanged so the score never wraps.
  function automatic logic [SCORE_W-1:0] bcd_inc_sat(input logic [SCORE_W-1:0] v);
    logic [BCD_DIGIT_W-1:0] hun;
    logic [BCD_DIGIT_W-1:0] ten;
    logic [BCD_DIGIT_W-1:0] one;
    {hun, ten, one} = v;
    if (v == SCORE_MAX) begin
      return v;
    end
    if (one == 4'd9) begin
      one = 4'd0;
      if (ten == 4'd9) begin
        ten = 4'd0;
        hun = hun + 4'd1;
      end else begin
        ten = ten + 4'd1;
      end
    end else begin
      one = one + 4'd1;
    end
    return {hun, ten, one};
  endfunction

endpackage
`default_nettype wire

// File: rtl/collision_game_ctrl_bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module  : collision_game_ctrl_bcd_score_counter
// Purpose : 3-digit saturating BCD score counter.
// Ports   : clk        in  system clock
//           resetN     in  asynchronous active-low reset
//           clear      in  synchronous clear to 0 (wins over inc)
//           inc        in  add one to the score (saturates at 999)
//           score_bcd  out {hundreds, tens, ones}
// Rev     : 1.0  initial release
// ============================================================================
module collision_game_ctrl_bcd_score_counter
  import collision_game_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] score_bcd
);

  logic [SCORE_W-1:0] r_score;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_score <= '0;
    end else if (clear) begin
      r_score <= '0;
    end else if (inc) begin
      r_score <= bcd_inc_sat(r_score);
    end
  end

  assign score_bcd = r_score;

endmodule
`default_nettype wire

// File: rtl/collision_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : collision_game_ctrl
// Purpose : Per-frame bird collision detection, game state FSM, pipe freeze
//           control and BCD score keeping.
// Ports   : clk            in  system clock
//           resetN         in  asynchronous active-low reset
//           startOfFrame   in  one-clk pulse at start of each VGA frame
//           drawing_bird   in  bird pixel active at current pixel
//           drawing_pipe   in  pipe pixel active at current pixel
//           drawing_ground in  ground pixel active at current pixel
//           pipe_passed    in  one-clk pulse when a pipe clears the bird
//           game_over      in  level from bird unit, forces OVER
//           start_pulse    in  debounced one-clk key pulse
//           collision_bird out one-clk, frame-aligned collision pulse
//           freeze_pipes   out level, pipe unit stops scrolling
//           game_state     out IDLE=0 PLAY=1 HIT=2 OVER=3
//           score_bcd      out 3 BCD digits {hundreds, tens, ones}
// Rev     : 1.0  initial release
// ============================================================================
module collision_game_ctrl
  import collision_game_ctrl_pkg::*;
#(
  parameter int HIT_FRAMES     = 30,
  parameter bit GROUND_COLLIDE = 1'b1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               drawing_bird,
  input  logic               drawing_pipe,
  input  logic               drawing_ground,
  input  logic               pipe_passed,
  input  logic               game_over,
  input  logic               start_pulse,
  output logic               collision_bird,
  output logic               freeze_pipes,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] score_bcd
);

  localparam int               CNT_W    = $clog2(HIT_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HIT_FRAMES - 1);

  game_state_e      r_state;
  game_state_e      w_state_next;
  logic             r_hit_flag;
  logic             r_collision;
  logic             r_freeze;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_overlap;
  logic             w_collide;
  logic             w_collision_next;
  logic             w_freeze_next;
  logic             w_score_clear;
  logic             w_score_inc;

  // Pixel-level overlap; ground only counts when enabled.
  assign w_overlap = drawing_bird & (drawing_pipe | (GROUND_COLLIDE & drawing_ground));

  // Collision is only decided at frame boundaries, from the flag gathered
  // over the previous frame.
  assign w_collide = startOfFrame & (r_state == ST_PLAY) & r_hit_flag;

  // hit_flag: set wins over the start-of-frame clear so an overlap on the
  // very first pixel of a frame is not lost.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit_flag <= 1'b0;
    end else if (w_overlap && (r_state == ST_PLAY)) begin
      r_hit_flag <= 1'b1;
    end else if (startOfFrame) begin
      r_hit_flag <= 1'b0;
    end
  end

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_collision <= 1'b0;
      r_freeze    <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_collision <= w_collision_next;
      r_freeze    <= w_freeze_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_pulse) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (game_over)      w_state_next = ST_OVER;
        else if (w_collide) w_state_next = ST_HIT;
      end
      ST_HIT: begin
        if (game_over)                                   w_state_next = ST_OVER;
        else if (startOfFrame && r_frame_cnt == CNT_LAST) w_state_next = ST_OVER;
      end
      ST_OVER: begin
        if (start_pulse) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic, computed from the upcoming state so the registered
  // outputs line up with game_state.
  always_comb begin
    w_freeze_next    = (w_state_next != ST_PLAY);
    // The pulse only fires on the PLAY->HIT transition, so game_over on the
    // same clk suppresses it and at most one pulse occurs per game.
    w_collision_next = (r_state == ST_PLAY) && (w_state_next == ST_HIT);
    w_score_clear    = (r_state == ST_IDLE) && start_pulse;
    w_score_inc      = (r_state == ST_PLAY) && pipe_passed;
  end

  // Frame counter: held at zero while playing so it starts at zero in HIT,
  // then counts frames and parks at its last value instead of wrapping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= '0;
    end else if (r_state == ST_PLAY) begin
      r_frame_cnt <= '0;
    end else if ((r_state == ST_HIT) && startOfFrame && (r_frame_cnt != CNT_LAST)) begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  collision_game_ctrl_bcd_score_counter u_score (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (w_score_clear),
    .inc       (w_score_inc),
    .score_bcd (score_bcd)
  );

  assign collision_bird = r_collision;
  assign freeze_pipes   = r_freeze;
  assign game_state     = r_state;

endmodule
`default_nettype wire
